// File: rtl/snake_pkg.sv
// Shared constants, colours and the BCD converter state type for the snake
// pixel renderer.
package snake_pkg;

    localparam int CELL_SIZE = 10;
    localparam int GRID_W    = 48;
    localparam int GRID_H    = 27;

    localparam logic [15:0] COL_BG     = 16'h0000;
    localparam logic [15:0] COL_BODY   = 16'h07E0;
    localparam logic [15:0] COL_APPLE  = 16'hF800;
    localparam logic [15:0] COL_BORDER = 16'h8410;
    localparam logic [15:0] COL_TEXT   = 16'hFFFF;
    localparam logic [15:0] COL_DEAD   = 16'hFFE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } bcd_state_e;

    // One double-dabble iteration on {hundreds, tens, ones, bin[6:0]}.
    function automatic logic [18:0] dabble_step(input logic [18:0] v);
        logic [18:0] a;
        a = v;
        for (int n = 0; n < 3; n++) begin
            if (a[7 + 4*n +: 4] >= 4'd5)
                a[7 + 4*n +: 4] = a[7 + 4*n +: 4] + 4'd3;
        end
        return {a[17:0], 1'b0};
    endfunction

endpackage

// File: rtl/snake_pixel_renderer_if.sv
// Pixel-stream bundle between the game-logic stage, the renderer and the LCD.
interface snake_pixel_renderer_if;
    import snake_pkg::*;

    logic        de;
    logic        hsync;
    logic        vsync;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        game_active;
    logic        is_body;
    logic        is_apple;
    logic        is_game_over;
    logic [6:0]  score;
    logic [15:0] rgb;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output de, hsync, vsync, draw_x, draw_y, game_active,
               is_body, is_apple, is_game_over, score,
        input  rgb, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  de, hsync, vsync, draw_x, draw_y, game_active,
               is_body, is_apple, is_game_over, score,
        output rgb, de_out, hsync_out, vsync_out
    );

endinterface

// File: rtl/digit_font_3x5.sv
// 3x5 digit glyph ROM; bits[2] is the leftmost column, codes 10..15 are blank.
module digit_font_3x5
    import snake_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [2:0] bits
);

    logic [14:0] glyph;

    always_comb begin
        glyph = 15'b0;
        case (digit)
            4'd0: glyph = 15'b111_101_101_101_111;
            4'd1: glyph = 15'b110_010_010_010_111;
            4'd2: glyph = 15'b111_001_111_100_111;
            4'd3: glyph = 15'b111_001_111_001_111;
            4'd4: glyph = 15'b101_101_111_001_001;
            4'd5: glyph = 15'b111_100_111_001_111;
            4'd6: glyph = 15'b111_100_111_101_111;
            4'd7: glyph = 15'b111_001_001_001_001;
            4'd8: glyph = 15'b111_101_111_101_111;
            4'd9: glyph = 15'b111_101_111_001_111;
            default: glyph = 15'b0;
        endcase
    end

    always_comb begin
        bits = 3'b000;
        case (row)
            3'd0: bits = glyph[14:12];
            3'd1: bits = glyph[11:9];
            3'd2: bits = glyph[8:6];
            3'd3: bits = glyph[5:3];
            3'd4: bits = glyph[2:0];
            default: bits = 3'b000;
        endcase
    end

endmodule

// File: rtl/snake_pixel_renderer.sv
// Final colour stage for the snake game: border, score overlay, game-over flash,
// two-stage pixel pipeline with matching sync delay.
//   state    | meaning
//   ST_IDLE  | waiting for a frame start to sample the score
//   ST_SHIFT | running the 7 double-dabble iterations
//   ST_LATCH | copying the BCD digits to the display registers
module snake_pixel_renderer
    import snake_pkg::*;
#(
    parameter int PF_W         = GRID_W * CELL_SIZE,
    parameter int PF_H         = GRID_H * CELL_SIZE,
    parameter int SCORE_X0     = 420,
    parameter int SCORE_Y0     = 4,
    parameter int FLASH_FRAMES = 30
) (
    input  logic                   clk_pix,
    input  logic                   rst_n,
    snake_pixel_renderer_if.slave  pix
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic de_s1_q, hs_s1_q, vs_s1_q, body_s1_q, apple_s1_q;
    logic active_s1_q, border_s1_q, text_s1_q;
    logic [15:0] rgb_q, rgb_d;
    logic de_s2_q, hs_s2_q, vs_s2_q;

    bcd_state_e  state_q, state_d;
    logic [18:0] shreg_q, shreg_d;
    logic [2:0]  iter_q, iter_d;
    logic [3:0]  disp_h_q, disp_t_q, disp_o_q;
    logic [3:0]  disp_h_d, disp_t_d, disp_o_d;

    logic [CNT_W-1:0] frame_cnt_q;
    logic             flash_q;
    logic             frame_start;

    assign frame_start = pix.vsync & ~vs_s1_q;

    // Overlay decode; the >= tests keep the offset subtraction from wrapping.
    logic [9:0] dx, dy;
    logic       in_rect, text_d, border_d, font_px;
    logic [1:0] slot, col;
    logic [2:0] row;
    logic [3:0] digit_sel;
    logic [2:0] font_bits;

    assign dx      = pix.draw_x - 10'(SCORE_X0);
    assign dy      = pix.draw_y - 10'(SCORE_Y0);
    assign in_rect = (pix.draw_x >= 10'(SCORE_X0)) && (dx < 10'd48) &&
                     (pix.draw_y >= 10'(SCORE_Y0)) && (dy < 10'd20);
    assign slot    = dx[5:4];
    assign col     = dx[3:2];
    assign row     = dy[4:2];
    assign border_d = (pix.draw_x >= 10'(PF_W)) || (pix.draw_y >= 10'(PF_H));

    always_comb begin
        digit_sel = 4'hF;
        case (slot)
            2'd0: digit_sel = (disp_h_q == 4'd0) ? 4'hF : disp_h_q;
            2'd1: digit_sel = (disp_h_q == 4'd0 && disp_t_q == 4'd0) ? 4'hF : disp_t_q;
            2'd2: digit_sel = disp_o_q;
            default: digit_sel = 4'hF;
        endcase
    end

    digit_font_3x5 u_font (
        .digit (digit_sel),
        .row   (row),
        .bits  (font_bits)
    );

    always_comb begin
        font_px = 1'b0;
        case (col)
            2'd0: font_px = font_bits[2];
            2'd1: font_px = font_bits[1];
            2'd2: font_px = font_bits[0];
            default: font_px = 1'b0;
        endcase
        text_d = in_rect & font_px;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            de_s1_q     <= 1'b0;
            hs_s1_q     <= 1'b0;
            vs_s1_q     <= 1'b0;
            body_s1_q   <= 1'b0;
            apple_s1_q  <= 1'b0;
            active_s1_q <= 1'b0;
            border_s1_q <= 1'b0;
            text_s1_q   <= 1'b0;
        end else begin
            de_s1_q     <= pix.de;
            hs_s1_q     <= pix.hsync;
            vs_s1_q     <= pix.vsync;
            body_s1_q   <= pix.is_body;
            apple_s1_q  <= pix.is_apple;
            active_s1_q <= pix.game_active;
            border_s1_q <= border_d;
            text_s1_q   <= text_d;
        end
    end

    always_comb begin
        rgb_d = COL_BG;
        if (!de_s1_q)              rgb_d = 16'h0000;
        else if (border_s1_q)      rgb_d = COL_BORDER;
        else if (!active_s1_q)     rgb_d = COL_BG;
        else if (text_s1_q)        rgb_d = COL_TEXT;
        else if (body_s1_q)        rgb_d = flash_q ? COL_DEAD : COL_BODY;
        else if (apple_s1_q)       rgb_d = COL_APPLE;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= 16'h0000;
            de_s2_q <= 1'b0;
            hs_s2_q <= 1'b0;
            vs_s2_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            de_s2_q <= de_s1_q;
            hs_s2_q <= hs_s1_q;
            vs_s2_q <= vs_s1_q;
        end
    end

    assign pix.rgb       = rgb_q;
    assign pix.de_out    = de_s2_q;
    assign pix.hsync_out = hs_s2_q;
    assign pix.vsync_out = vs_s2_q;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        iter_d   = iter_q;
        disp_h_d = disp_h_q;
        disp_t_d = disp_t_q;
        disp_o_d = disp_o_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    shreg_d = {12'd0, pix.score};
                    iter_d  = 3'd6;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = dabble_step(shreg_q);
                if (iter_q == 3'd0) state_d = ST_LATCH;
                else                iter_d  = iter_q - 3'd1;
            end
            ST_LATCH: begin
                disp_h_d = shreg_q[18:15];
                disp_t_d = shreg_q[14:11];
                disp_o_d = shreg_q[10:7];
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= 19'd0;
            iter_q   <= 3'd0;
            disp_h_q <= 4'd0;
            disp_t_q <= 4'd0;
            disp_o_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            iter_q   <= iter_d;
            disp_h_q <= disp_h_d;
            disp_t_q <= disp_t_d;
            disp_o_q <= disp_o_d;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else if (!pix.is_game_over) begin
            frame_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                flash_q     <= ~flash_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Scoreboard bench for snake_pixel_renderer: every driven cycle queues its
// expected colour and syncs, compared when they emerge two clocks later.
module tb_snake_pixel_renderer;
    import snake_pkg::*;

    logic clk_pix = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_pix = ~clk_pix;

    snake_pixel_renderer_if pix ();

    snake_pixel_renderer dut (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .pix     (pix)
    );

    int total = 0;
    int bad   = 0;
    logic [18:0] exp_q[$];
    string       tag_q[$];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic de, input logic hs, input logic vs,
                        input int x, input int y, input logic body, input logic apple,
                        input logic [15:0] exp_rgb);
        logic [18:0] e;
        string       t;
        pix.de       = de;
        pix.hsync    = hs;
        pix.vsync    = vs;
        pix.draw_x   = 10'(x);
        pix.draw_y   = 10'(y);
        pix.is_body  = body;
        pix.is_apple = apple;
        exp_q.push_back({exp_rgb, de, hs, vs});
        tag_q.push_back(tag);
        @(posedge clk_pix);
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk_val($sformatf("%s_rgb", t), 32'(pix.rgb), 32'(e[18:3]));
            chk_val($sformatf("%s_sync", t),
                    32'({pix.de_out, pix.hsync_out, pix.vsync_out}), 32'(e[2:0]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic vs_pulse();
        step("vs", 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    endtask

    initial begin
        pix.de = 0; pix.hsync = 0; pix.vsync = 0;
        pix.draw_x = 0; pix.draw_y = 0;
        pix.game_active = 1; pix.is_body = 0; pix.is_apple = 0;
        pix.is_game_over = 0; pix.score = 7'd0;
        repeat (3) @(posedge clk_pix);
        #1 rst_n = 1'b1;

        // Reset digits are 0/0/0: only the ones '0' is visible.
        step("rst_hund_blank", 1, 0, 0, 420, 4, 0, 0, COL_BG);
        step("rst_ones_zero",  1, 0, 0, 452, 4, 0, 0, COL_TEXT);
        step("border_a",       1, 0, 0, 500, 10, 0, 0, COL_BORDER);
        step("border_b",       1, 0, 0, 501, 10, 0, 0, COL_BORDER);
        step("border_c",       1, 0, 0, 502, 10, 0, 0, COL_BORDER);

        // Mid-line asynchronous reset.
        rst_n = 1'b0;
        #1;
        chk_val("async_rst_rgb",  32'(pix.rgb), 32'h0);
        chk_val("async_rst_sync", 32'({pix.de_out, pix.hsync_out, pix.vsync_out}), 32'h0);
        exp_q.delete();
        tag_q.delete();
        pix.de = 0;
        repeat (2) @(posedge clk_pix);
        #1 rst_n = 1'b1;
        step("first_px", 1, 0, 0, 0, 0, 0, 0, 16'h0000);
        idle(2);

        // Score 105.
        pix.score = 7'd105;
        vs_pulse();
        idle(12);
        step("s105_h1_tl",  1, 0, 0, 420, 4,  0, 0, COL_TEXT);
        step("s105_gap",    1, 0, 0, 432, 4,  0, 0, COL_BG);
        step("s105_t0_tl",  1, 0, 0, 436, 4,  0, 0, COL_TEXT);
        step("s105_t0_mid", 1, 0, 0, 440, 8,  0, 0, COL_BG);
        step("s105_o5_r2",  1, 0, 0, 452, 12, 0, 0, COL_TEXT);
        step("s105_o5_r1",  1, 0, 0, 456, 8,  0, 0, COL_BG);
        idle(2);

        // Score 7 with leading-zero suppression, then a mid-frame change.
        pix.score = 7'd7;
        vs_pulse();
        idle(12);
        step("s7_hund", 1, 0, 0, 420, 4, 0, 0, COL_BG);
        step("s7_tens", 1, 0, 0, 436, 4, 0, 0, COL_BG);
        step("s7_r0c0", 1, 0, 0, 452, 4, 0, 0, COL_TEXT);
        step("s7_r1c0", 1, 0, 0, 452, 8, 0, 0, COL_BG);
        step("s7_r1c2", 1, 0, 0, 460, 8, 0, 0, COL_TEXT);
        pix.score = 7'd12;
        idle(12);
        step("hold7_tens", 1, 0, 0, 436, 4, 0, 0, COL_BG);
        step("hold7_r1c0", 1, 0, 0, 452, 8, 0, 0, COL_BG);
        vs_pulse();
        pix.score = 7'd99;
        idle(12);
        step("s12_hund",  1, 0, 0, 420, 4,  0, 0, COL_BG);
        step("s12_tens1", 1, 0, 0, 436, 4,  0, 0, COL_TEXT);
        step("s12_r1c2",  1, 0, 0, 460, 8,  0, 0, COL_TEXT);
        step("s12_r1c0",  1, 0, 0, 452, 8,  0, 0, COL_BG);
        step("s12_r3c0",  1, 0, 0, 452, 16, 0, 0, COL_TEXT);
        pix.score = 7'd12;
        idle(2);

        // Colour priority.
        step("text_over_body", 1, 0, 0, 436, 4,  1, 0, COL_TEXT);
        step("body_over_apple",1, 0, 0, 100, 50, 1, 1, COL_BODY);
        step("apple_edge",     1, 0, 0, 479, 0,  0, 1, COL_APPLE);
        step("border_x480",    1, 0, 0, 480, 0,  0, 1, COL_BORDER);
        step("border_y270",    1, 0, 0, 0,   270,0, 1, COL_BORDER);
        step("y269_bg",        1, 0, 0, 0,   269,0, 0, COL_BG);
        step("de_low_body",    0, 0, 0, 100, 100,1, 0, 16'h0000);
        pix.game_active = 0;
        step("inactive_body",   1, 0, 0, 100, 100, 1, 0, COL_BG);
        step("inactive_border", 1, 0, 0, 480, 0,   0, 0, COL_BORDER);
        step("inactive_text",   1, 0, 0, 436, 4,   0, 0, COL_BG);
        pix.game_active = 1;

        // Sync re-timing.
        step("hs_only",  0, 1, 0, 0, 0, 0, 0, 16'h0000);
        step("hs_de",    1, 1, 0, 10, 10, 0, 0, COL_BG);
        step("hs_vs",    0, 1, 1, 0, 0, 0, 0, 16'h0000);
        idle(3);

        // Game-over flash over 90 frames.
        pix.is_game_over = 1;
        step("flash_f0", 1, 0, 0, 100, 100, 1, 0, COL_BODY);
        idle(2);
        for (int f = 1; f <= 90; f++) begin
            vs_pulse();
            idle(2);
            step($sformatf("flash_f%0d", f), 1, 0, 0, 100, 100, 1, 0,
                 (((f / 30) % 2) == 1) ? COL_DEAD : COL_BODY);
        end
        pix.is_game_over = 0;
        step("go_clear", 1, 0, 0, 100, 100, 1, 0, COL_BODY);
        vs_pulse();
        idle(2);
        step("go_clear_hold", 1, 0, 0, 100, 100, 1, 0, COL_BODY);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_pixel_renderer.md
Name: snake_pixel_renderer

Overview:
- Downstream of the snake game-logic stage; consumes its per-pixel is_body / is_apple flags, score and game-over status.
- Produces the final RGB565 pixel stream for a 480x272 LCD panel.
- Adds a playfield border, a 3-digit score overlay (sequential binary-to-BCD conversion, 3x5 font), and game-over body flashing.
- Re-times de/hsync/vsync to match its 2-cycle pixel latency.

Parameters:
- PF_W, 480, playfield width in pixels (48 cells x 10).
- PF_H, 270, playfield height in pixels (27 cells x 10).
- SCORE_X0, 420, left x of the score overlay.
- SCORE_Y0, 4, top y of the score overlay.
- FLASH_FRAMES, 30, frames per game-over flash phase.
- COL_BG, 16'h0000, background colour.
- COL_BODY, 16'h07E0, snake colour.
- COL_APPLE, 16'hF800, apple colour.
- COL_BORDER, 16'h8410, colour outside the playfield.
- COL_TEXT, 16'hFFFF, score glyph colour.
- COL_DEAD, 16'hFFE0, body colour in flash phase 1.

Ports:
- clk_pix  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- de  in  1  data enable from the timing generator
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync, active high
- draw_x  in  10  current pixel x, same cycle as de
- draw_y  in  10  current pixel y
- game_active  in  1  game selected in the console menu
- is_body  in  1  snake pixel flag, valid in the same cycle as draw_x/draw_y
- is_apple  in  1  apple pixel flag, same cycle
- is_game_over  in  1  game-over state
- score  in  7  current score, 0..127
- rgb  out  16  RGB565 pixel
- de_out  out  1  de delayed by 2
- hsync_out  out  1  hsync delayed by 2
- vsync_out  out  1  vsync delayed by 2

Behaviour:
- Reset (async): rgb=0, de_out=0, hsync_out=0, vsync_out=0. BCD digits=0, converter IDLE, frame_cnt=0, flash_phase=0.
- Latency: rgb, de_out, hsync_out and vsync_out are exactly 2 clk_pix after the inputs.
  - Stage 1 registers the flags, coordinates, glyph lookup and region decode.
  - Stage 2 registers the colour.
- Frame start: rising edge of vsync, detected with a registered copy of vsync.
- BCD converter FSM:
  - IDLE -> SHIFT on frame start. Samples score into a shift register.
  - SHIFT: 7 double-dabble iterations (add 3 to any nibble >=5, then shift left), one per cycle.
  - SHIFT -> LATCH after the 7th iteration. LATCH writes disp_h/disp_t/disp_o, then returns to IDLE.
  - A frame start while not IDLE is ignored.
  - Score changes mid-conversion or mid-frame do not affect the displayed digits until the next latch.
- Score overlay: 3 digit slots, each 16 px wide.
  - Glyph is 3x5, scaled x4 (12x20 px); slot columns 12..15 are a gap.
  - dx = draw_x - SCORE_X0; slot = dx>>4; col = (dx[3:0])>>2 (col 3 = gap); row = (draw_y - SCORE_Y0)>>2, valid for rows 0..4.
  - Text pixel = inside the overlay rectangle AND font bit set.
  - Leading-zero suppression: hundreds blank if 0; tens blank if hundreds=0 and tens=0. The ones digit is always shown.
- Flash:
  - While is_game_over=1, frame_cnt counts frames 0..FLASH_FRAMES-1; on wrap flash_phase toggles.
  - While is_game_over=0, frame_cnt=0 and flash_phase=0.
- Colour priority, highest first:
  1. de=0 -> 0.
  2. Outside the playfield (x>=PF_W or y>=PF_H) -> COL_BORDER.
  3. game_active=0 -> COL_BG.
  4. Text pixel -> COL_TEXT.
  5. is_body -> COL_DEAD if flash_phase else COL_BODY.
  6. is_apple -> COL_APPLE.
  7. Otherwise COL_BG.
- Coordinate subtraction underflow: the overlay compare uses draw_x >= SCORE_X0 and draw_y >= SCORE_Y0 before the offset, so there is no wrap-around hit.

Decomposition:
- Shared package snake_pkg:
  - Grid constants (CELL_SIZE=10, GRID_W=48, GRID_H=27).
  - RGB565 colour constants.
  - Converter state enum (IDLE, SHIFT, LATCH).
- Sub-module digit_font_3x5: combinational ROM with digit[3:0] and row[2:0] in, bits[2:0] out. Digits 10..15 return 0.

Test Plan:
- Reset asserted mid-line -> all outputs 0 immediately. After release, the first de=1 pixel (x=0,y=0, no flags) gives rgb=16'h0000 two cycles later with de_out=1.
- score=105, one vsync rising edge -> digits latched 1/0/5 within 9 cycles. Pixel (420,4) = COL_TEXT (top-left of '1' glyph set per font). Pixel (432,4) (gap) = COL_BG.
- score=7 -> hundreds and tens slots all COL_BG. Score changed to 12 mid-frame -> overlay still shows 7 until the next vsync, then 12.
- is_body=1 at (100,100), is_game_over=1 -> COL_BODY for frames 0..29, COL_DEAD for frames 30..59, COL_BODY at frame 60. Deasserting is_game_over -> COL_BODY next pixel.
- is_body=1 and a text pixel at the same coordinate -> COL_TEXT. is_apple=1 at (479,0) -> COL_APPLE. At (480,0) -> COL_BORDER. At (0,270) -> COL_BORDER.
- game_active=0 with is_body=1 inside the playfield -> COL_BG. hsync/vsync pulses are reproduced on the outputs exactly 2 cycles later.
